if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decoder.
- Holds the fetch PC and issues word requests on a req/gnt/rvalid instruction-memory port.
- Buffers returned words with their PC in a small FIFO, and presents them to the decode pipeline register over a valid/ready handshake.
- Redirects from later stages (branch/jump/trap) flush the FIFO and discard any in-flight response.

Parameters:
- RESET_PC, 32'h8000_0000: fetch address after reset.
- FIFO_DEPTH, 2: instruction buffer entries. Must be a power of two and at least 2.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- imem_req  output  1  fetch request
- imem_addr  output  32  word address of request; [1:0] always 2'b00
- imem_gnt  input  1  request accepted this cycle (sampled only when imem_req=1)
- imem_rvalid  input  1  response valid
- imem_rdata  input  32  instruction word
- imem_err  input  1  access fault, qualified by imem_rvalid
- redirect_valid  input  1  flush and restart fetch
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored (treated as 0)
- out_valid  output  1  FIFO head valid
- out_ready  input  1  decode accepts head
- out_pc  output  32  PC of head instruction
- out_ins  output  32  instruction word of head
- out_fault  output  1  head fetch faulted

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=BOOT, fetch_pc=RESET_PC, FIFO empty.
  - imem_req=0, imem_addr=RESET_PC, out_valid=0.
- Empty-FIFO outputs: out_pc=0, out_ins=32'h0000_0013 (NOP), out_fault=0. When non-empty, out_* is driven combinationally from the FIFO head.
- Bus rules:
  - Slave samples imem_addr only on imem_req&&imem_gnt.
  - imem_req/imem_addr may change in any cycle without a grant.
  - At most one request is outstanding.
  - Exactly one rvalid per grant, arriving at least 1 cycle after it.
- FSM states (one-hot or binary enum):
  - BOOT: unconditionally go to REQ next cycle.
  - REQ: imem_req = (count < FIFO_DEPTH); imem_addr = fetch_pc. On req&&gnt: fetch_pc += 4 (wraps mod 2^32), go to WAIT.
  - WAIT: imem_req=0. On rvalid: push {pc_of_request, rdata, err}, go to REQ. The pc_of_request register is captured at grant.
  - DRAIN: imem_req=0. Next rvalid is discarded (no push), then go to REQ.
- Redirect (highest priority, any state except BOOT; also honoured in BOOT by setting fetch_pc):
  - fetch_pc <= {redirect_pc[31:2],2'b00}; FIFO cleared (count=0) next cycle.
  - From REQ with gnt in the same cycle: go to DRAIN.
  - From REQ without gnt: stay in REQ; the next request uses the new PC.
  - From WAIT with rvalid in the same cycle: response dropped, go to REQ.
  - From WAIT without rvalid: go to DRAIN.
  - From DRAIN with rvalid in the same cycle: go to REQ; otherwise stay in DRAIN.
  - A same-cycle out_valid&&out_ready counts as a completed transfer; the flush still empties the remainder.
- FIFO:
  - Push and pop in the same cycle are both allowed; count is unchanged.
  - Push never occurs when full; this is guaranteed by the count<FIFO_DEPTH check at issue, since pops only reduce count while outstanding. Push-when-full is an assertion failure.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency:
  - rvalid to out_valid: 1 cycle (registered push, no bypass).
  - First imem_req: 1 cycle after reset release.
  - Peak throughput: 1 instruction per 2 cycles plus memory latency.
- Faulted fetches are delivered normally with out_fault=1 and out_ins=rdata. Fetch continues sequentially; decode/trap logic issues the redirect.
- Reset asserted mid-transaction: state returns to BOOT. A stale rvalid arriving in BOOT/REQ is ignored (no push); assertion-warn only.

Decomposition:
- Shared package fetch_pkg:
  - NOP_INSN = 32'h0000_0013.
  - fetch_state_t enum {BOOT, REQ, WAIT, DRAIN}.
  - fetch_pkt_t struct {pc[31:0], ins[31:0], fault}.
- Sub-module fetch_fifo (parameter DEPTH, payload fetch_pkt_t):
  - Ports: push, pop, flush, head, count, full, empty.
  - Reused later for the decode queue.

Test Plan:
- Reset release, memory grants immediately and returns rdata=32'h0000_0093 one cycle later -> imem_addr=8000_0000 then 8000_0004; out_valid with out_pc=8000_0000, out_ins=0000_0093.
- out_ready held 0, memory always responsive -> exactly FIFO_DEPTH=2 words buffered, then imem_req stays 0; raising out_ready drains pcs 8000_0000, 8000_0004 in order, and fetch resumes at 8000_0008.
- Redirect to 32'h0000_1002 while in WAIT, rvalid arrives 3 cycles later -> that word is not delivered; next imem_addr=0000_1000 and the first out_pc=0000_1000.
- Redirect in the same cycle as rvalid -> response dropped, no DRAIN, next request at the redirect PC the following cycle; FIFO empty (out_valid=0, out_ins=NOP).
- imem_err=1 with rvalid at PC 8000_0004 -> out_fault=1 for that entry only; the next entry, 8000_0008, has out_fault=0.
- rst_n low for one cycle while in WAIT -> all outputs at reset values; the late rvalid is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage.
// Fetched packets are also used by the decode queue.
package fetch_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    WAIT,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        fault;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetch packets.
// Flush empties it in one cycle; head is combinational.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_pkt_t             din,
  output fetch_pkt_t             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_pkt_t     mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic           do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign do_pop = pop && !empty;
  assign head   = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_push_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(push && full)
  );

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC, one-outstanding imem port,
// buffered words handed to decode over valid/ready.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_ins,
  output logic        out_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t   state;
  logic [31:0]    fetch_pc;
  logic [31:0]    req_pc;
  logic           push;
  logic           pop;
  logic           full;
  logic           empty;
  logic [CW-1:0]  count;
  fetch_pkt_t     din;
  fetch_pkt_t     head;

  assign imem_req  = (state == REQ) && !full;
  assign imem_addr = fetch_pc;

  // A redirect kills the response in the same cycle
  assign push = (state == WAIT) && imem_rvalid && !redirect_valid;
  assign pop  = out_valid && out_ready;
  assign din  = '{pc: req_pc, ins: imem_rdata, fault: imem_err};

  assign out_valid = !empty;
  assign out_pc    = empty ? 32'h0 : head.pc;
  assign out_ins   = empty ? NOP_INSN : head.ins;
  assign out_fault = empty ? 1'b0 : head.fault;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      unique case (state)
        BOOT:    state <= REQ;
        REQ:     state <= (imem_req && imem_gnt) ? DRAIN : REQ;
        WAIT:    state <= imem_rvalid ? REQ : DRAIN;
        DRAIN:   state <= imem_rvalid ? REQ : DRAIN;
        default: state <= BOOT;
      endcase
    end else begin
      unique case (state)
        BOOT: state <= REQ;
        REQ: begin
          if (imem_req && imem_gnt) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= WAIT;
          end
        end
        WAIT:    if (imem_rvalid) state <= REQ;
        DRAIN:   if (imem_rvalid) state <= REQ;
        default: state <= BOOT;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed cycle-by-cycle vectors for if_fetch_unit.
// Each row: inputs for one cycle and outputs expected in it.
module tb_if_fetch_unit;

  localparam logic [31:0] B   = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    bit          rst;
    bit          gnt;
    bit          rv;
    logic [31:0] rd;
    bit          er;
    bit          rdv;
    logic [31:0] rpc;
    bit          rdy;
    bit          e_req;
    bit          ca;
    logic [31:0] e_addr;
    bit          e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    bit          e_f;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_ins;
  logic        out_fault;

  int n_cmp = 0;
  int n_bad = 0;

  if_fetch_unit #(
    .RESET_PC   (32'h8000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .imem_err       (imem_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_ins        (out_ins),
    .out_fault      (out_fault)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    bit rst, bit gnt, bit rv, logic [31:0] rd, bit er,
    bit rdv, logic [31:0] rpc, bit rdy,
    bit ereq, bit ca, logic [31:0] eaddr,
    bit eov, logic [31:0] epc, logic [31:0] eins, bit ef
  );
    vec_t v;
    v.rst = rst; v.gnt = gnt; v.rv = rv; v.rd = rd; v.er = er;
    v.rdv = rdv; v.rpc = rpc; v.rdy = rdy;
    v.e_req = ereq; v.ca = ca; v.e_addr = eaddr;
    v.e_ov = eov;
    v.e_pc  = eov ? epc : 32'h0;
    v.e_ins = eov ? eins : NOP;
    v.e_f   = eov ? ef : 1'b0;
    return v;
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_row(vec_t v, string tag);
    rst_n          = v.rst;
    imem_gnt       = v.gnt;
    imem_rvalid    = v.rv;
    imem_rdata     = v.rd;
    imem_err       = v.er;
    redirect_valid = v.rdv;
    redirect_pc    = v.rpc;
    out_ready      = v.rdy;
    @(negedge clk);
    cmp({tag, ".req"}, 32'(imem_req), 32'(v.e_req));
    if (v.ca) cmp({tag, ".addr"}, imem_addr, v.e_addr);
    cmp({tag, ".ov"}, 32'(out_valid), 32'(v.e_ov));
    cmp({tag, ".pc"}, out_pc, v.e_pc);
    cmp({tag, ".ins"}, out_ins, v.e_ins);
    cmp({tag, ".flt"}, 32'(out_fault), 32'(v.e_f));
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[12];
  vec_t rst_row;

  initial begin
    rst_row = mk(0,0,0,0,0,0,0,0, 0,1,B, 0,0,0,0);

    tbl[0]  = mk(1,0,0,0,0,0,0,0, 0,0,0, 0,0,0,0);
    tbl[1]  = mk(1,1,0,0,0,0,0,0, 1,1,B, 0,0,0,0);
    tbl[2]  = mk(1,0,1,32'h0000_0093,0,0,0,0, 0,0,0, 0,0,0,0);
    tbl[3]  = mk(1,1,0,0,0,0,0,0, 1,1,B+4, 1,B,32'h93,0);
    tbl[4]  = mk(1,0,1,32'h0010_0113,1,0,0,0, 0,0,0, 1,B,32'h93,0);
    tbl[5]  = mk(1,1,0,0,0,0,0,0, 0,0,0, 1,B,32'h93,0);
    tbl[6]  = mk(1,1,0,0,0,0,0,0, 0,0,0, 1,B,32'h93,0);
    tbl[7]  = mk(1,1,0,0,0,0,0,1, 0,0,0, 1,B,32'h93,0);
    tbl[8]  = mk(1,1,0,0,0,0,0,1, 1,1,B+8, 1,B+4,32'h0010_0113,1);
    tbl[9]  = mk(1,0,1,32'h0020_0193,0,0,0,1, 0,0,0, 0,0,0,0);
    tbl[10] = mk(1,0,0,0,0,0,0,1, 1,1,B+12, 1,B+8,32'h0020_0193,0);
    tbl[11] = mk(1,0,0,0,0,0,0,0, 1,1,B+12, 0,0,0,0);

    rst_n = 1'b0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; imem_err = 0;
    redirect_valid = 0; redirect_pc = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    run_row(rst_row, "reset");

    for (int i = 0; i < 12; i++) begin
      run_row(tbl[i], $sformatf("tbl%0d", i));
    end

    // redirect while waiting; late response must be dropped
    run_row(mk(1,1,0,0,0,0,0,0, 1,1,B+12, 0,0,0,0), "a1");
    run_row(mk(1,0,0,0,0,1,32'h0000_1002,0, 0,0,0, 0,0,0,0), "a2");
    run_row(mk(1,0,0,0,0,0,0,0, 0,0,0, 0,0,0,0), "a3");
    run_row(mk(1,0,0,0,0,0,0,0, 0,0,0, 0,0,0,0), "a4");
    run_row(mk(1,0,1,32'hDEAD_BEEF,0,0,0,0, 0,0,0, 0,0,0,0), "a5");
    run_row(mk(1,1,0,0,0,0,0,0, 1,1,32'h1000, 0,0,0,0), "a6");
    run_row(mk(1,0,1,32'h0030_0213,0,0,0,0, 0,0,0, 0,0,0,0), "a7");
    run_row(mk(1,0,0,0,0,0,0,0,
               1,1,32'h1004, 1,32'h1000,32'h0030_0213,0), "a8");

    // redirect together with rvalid: no drain, FIFO flushed
    run_row(mk(1,1,0,0,0,0,0,0,
               1,1,32'h1004, 1,32'h1000,32'h0030_0213,0), "b1");
    run_row(mk(1,0,1,32'hBADB_AD00,0,1,32'h0000_2000,0,
               0,0,0, 1,32'h1000,32'h0030_0213,0), "b2");
    run_row(mk(1,0,0,0,0,0,0,0, 1,1,32'h2000, 0,0,0,0), "b3");

    // reset during WAIT; stale rvalid afterwards ignored
    run_row(mk(1,1,0,0,0,0,0,0, 1,1,32'h2000, 0,0,0,0), "c1");
    run_row(mk(0,0,0,0,0,0,0,0, 0,0,0, 0,0,0,0), "c2");
    run_row(mk(1,0,1,32'hCAFE_F00D,0,0,0,0, 0,1,B, 0,0,0,0), "c3");
    run_row(mk(1,0,0,0,0,0,0,0, 1,1,B, 0,0,0,0), "c4");
    run_row(mk(1,1,0,0,0,0,0,0, 1,1,B, 0,0,0,0), "c5");
    run_row(mk(1,0,1,32'h0040_0293,0,0,0,0, 0,0,0, 0,0,0,0), "c6");
    run_row(mk(1,0,0,0,0,0,0,1,
               1,1,B+4, 1,B,32'h0040_0293,0), "c7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
